uart_frame_rx: RTL



---
 rtl/uart_frame_pkg.sv | 21 ++
 rtl/uart_frame_timeout.sv | 39 +++
 rtl/uart_frame_rx.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame receiver: parser states,
// verdict error codes and the default start-of-frame marker.
package uart_frame_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LEN     = 2'd1,
      ST_PAYLOAD = 2'd2,
      ST_CSUM    = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_CSUM    = 2'd1,
      ERR_LEN     = 2'd2,
      ERR_TIMEOUT = 2'd3
   } err_code_e;

   localparam logic [7:0] SOF_DEFAULT = 8'h7E;

endpackage

// File: rtl/uart_frame_timeout.sv
// Inter-byte watchdog: counts ticks up to TimeoutCycles and holds there,
// flagging expiry until cleared.
module uart_frame_timeout #(
   parameter int unsigned TimeoutCycles = 10_000
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clear,
   input  logic i_tick,
   output logic o_expired
);

   localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
   localparam logic [CntW-1:0] Term = CntW'(TimeoutCycles);

   logic [CntW-1:0] cnt_q, cnt_d;

   // NOTE: the default assignment first means every path assigns cnt_d, so no latch is inferred.
   always_comb begin
      cnt_d = cnt_q;
      if (i_clear) begin
         cnt_d = '0;
      end else if (i_tick && (cnt_q != Term)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_expired = (cnt_q == Term);

endmodule

// File: rtl/uart_frame_rx.sv
// Pops bytes from the UART RX FIFO, hunts for SOF, parses LEN/payload/CSUM
// frames, streams payload on valid/ready and pulses an ok/error verdict.
module uart_frame_rx
   import uart_frame_pkg::*;
#(
   parameter logic [7:0]  SofByte       = SOF_DEFAULT,
   parameter int unsigned MaxLen        = 64,
   parameter int unsigned TimeoutCycles = 10_000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_rx_rdy,
   input  logic [7:0]  i_rx_data,
   output logic        o_rx_req,
   output logic [7:0]  o_pl_data,
   output logic        o_pl_valid,
   input  logic        i_pl_ready,
   output logic        o_pl_last,
   output logic        o_frame_ok,
   output logic        o_frame_err,
   output logic [1:0]  o_err_code,
   output logic [15:0] o_ok_count,
   output logic [7:0]  o_err_count
);

   localparam logic [7:0] MaxLenB = 8'(MaxLen);

   state_e     state_q;
   logic [7:0] sum_q, remain_q, pl_data_q;
   logic       pl_valid_q, pl_last_q, ok_q, err_q;
   err_code_e  err_code_q;
   logic [15:0] ok_cnt_q;
   logic [7:0]  err_cnt_q;

   logic       pop_allowed, pop, expired, timed_out;
   logic       ok_set, err_set;
   err_code_e  err_set_code;
   logic [7:0] sum_next;

   // NOTE: kept as an 8-bit net so the zero test wraps; inline it would widen and keep the carry.
   assign sum_next = sum_q + i_rx_data;

   always_comb begin
      pop_allowed = 1'b0;
      unique case (state_q)
         ST_IDLE, ST_LEN: pop_allowed = 1'b1;
         ST_PAYLOAD:      pop_allowed = !pl_valid_q || i_pl_ready;
         ST_CSUM:         pop_allowed = !pl_valid_q;
         default:         pop_allowed = 1'b0;
      endcase
   end

   // An expiring frame must not swallow a byte that belongs to the next one.
   assign timed_out = expired && (state_q != ST_IDLE);
   assign pop       = i_rx_rdy && pop_allowed && !timed_out && !i_rst;
   assign o_rx_req  = pop;

   always_comb begin
      ok_set       = 1'b0;
      err_set      = 1'b0;
      err_set_code = ERR_NONE;
      if (timed_out) begin
         err_set      = 1'b1;
         err_set_code = ERR_TIMEOUT;
      end else if (pop && (state_q == ST_LEN) && (i_rx_data > MaxLenB)) begin
         err_set      = 1'b1;
         err_set_code = ERR_LEN;
      end else if (pop && (state_q == ST_CSUM)) begin
         if (sum_next == 8'd0) begin
            ok_set = 1'b1;
         end else begin
            err_set      = 1'b1;
            err_set_code = ERR_CSUM;
         end
      end
   end

   uart_frame_timeout #(.TimeoutCycles(TimeoutCycles)) u_timeout (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_clear   (pop || (state_q == ST_IDLE)),
      .i_tick    ((state_q != ST_IDLE) && !i_rx_rdy),
      .o_expired (expired)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= ST_IDLE;
         sum_q      <= '0;
         remain_q   <= '0;
         pl_data_q  <= '0;
         pl_valid_q <= 1'b0;
         pl_last_q  <= 1'b0;
         ok_q       <= 1'b0;
         err_q      <= 1'b0;
         err_code_q <= ERR_NONE;
         ok_cnt_q   <= '0;
         err_cnt_q  <= '0;
      end else begin
         ok_q       <= ok_set;
         err_q      <= err_set;
         err_code_q <= err_set_code;
         if (ok_set && (ok_cnt_q != 16'hFFFF)) ok_cnt_q <= ok_cnt_q + 1'b1;
         if (err_set && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 1'b1;

         if (pl_valid_q && i_pl_ready) begin
            pl_valid_q <= 1'b0;
            pl_last_q  <= 1'b0;
         end

         if (timed_out) begin
            state_q <= ST_IDLE;
         end else if (pop) begin
            unique case (state_q)
               ST_IDLE: begin
                  if (i_rx_data == SofByte) begin
                     state_q <= ST_LEN;
                     sum_q   <= '0;
                  end
               end
               ST_LEN: begin
                  sum_q <= i_rx_data;
                  if (i_rx_data == 8'd0) begin
                     state_q <= ST_CSUM;
                  end else if (i_rx_data > MaxLenB) begin
                     state_q <= ST_IDLE;
                  end else begin
                     remain_q <= i_rx_data;
                     state_q  <= ST_PAYLOAD;
                  end
               end
               ST_PAYLOAD: begin
                  sum_q      <= sum_next;
                  pl_data_q  <= i_rx_data;
                  pl_valid_q <= 1'b1;
                  pl_last_q  <= (remain_q == 8'd1);
                  remain_q   <= remain_q - 1'b1;
                  if (remain_q == 8'd1) state_q <= ST_CSUM;
               end
               ST_CSUM: begin
                  sum_q   <= sum_next;
                  state_q <= ST_IDLE;
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign o_pl_data   = pl_data_q;
   assign o_pl_valid  = pl_valid_q;
   assign o_pl_last   = pl_last_q;
   assign o_frame_ok  = ok_q;
   assign o_frame_err = err_q;
   assign o_err_code  = err_code_q;
   assign o_ok_count  = ok_cnt_q;
   assign o_err_count = err_cnt_q;

endmodule
